// File: rtl/trivium_stream_gen_if.sv
// Control and keystream-stream bundle of the Trivium generator.
// The generator takes the master side and the cipher/control logic takes the slave side.
interface trivium_stream_gen_if #(
  parameter int W     = 8,
  parameter int CNT_W = 32
);
  logic             load;
  logic [79:0]      key;
  logic [79:0]      iv;
  logic             busy;
  logic             ks_valid;
  logic             ks_ready;
  logic [W-1:0]     ks_data;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    input  load, key, iv, ks_ready,
    output busy, ks_valid, ks_data, word_cnt
  );

  modport slave (
    output load, key, iv, ks_ready,
    input  busy, ks_valid, ks_data, word_cnt
  );
endinterface

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator that computes W chained rounds per clock.
// After a load it runs a multi-cycle warm-up and then streams W-bit words over valid/ready.
module trivium_stream_gen #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  trivium_stream_gen_if.master bus
);
  localparam int CTR_W = $clog2(INIT_ROUNDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [287:0]     s_r, s_nxt_s, s_adv_s, s_load_s;
  logic [W-1:0]     z_s;
  logic [CTR_W-1:0] ctr_r, ctr_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             ks_valid_r, ks_valid_nxt_s;
  logic [W-1:0]     ks_data_r, ks_data_nxt_s;
  logic [CNT_W-1:0] word_cnt_r, word_cnt_nxt_s;
  logic             advance_s, handshake_s, init_last_s;

  // Bit s_k of the cipher state lives at s[k-1]; result is {z, next state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  assign s_load_s    = {3'b111, 112'd0, bus.iv, 13'd0, bus.key};
  assign init_last_s = (ctr_r == CTR_W'(INIT_ROUNDS - W));
  assign handshake_s = ks_valid_r & bus.ks_ready;
  assign advance_s   = ~ks_valid_r | bus.ks_ready;

  // Chain W rounds in one clock; round j produces keystream bit j.
  always_comb begin
    logic [287:0] chain;
    logic [288:0] rnd;
    chain = s_r;
    rnd   = 289'd0;
    z_s   = '0;
    for (int j = 0; j < W; j++) begin
      rnd    = trivium_round(chain);
      z_s[j] = rnd[288];
      chain  = rnd[287:0];
    end
    s_adv_s = chain;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a load restarts warm-up from any state
  always_comb begin
    state_nxt_s = state_r;
    if (bus.load) begin
      state_nxt_s = ST_INIT;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_INIT: begin
          if (init_last_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_INIT;
          end
        end
        ST_RUN:  state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next values of cipher state, counters and stream outputs
  always_comb begin
    s_nxt_s        = s_r;
    ctr_nxt_s      = ctr_r;
    busy_nxt_s     = busy_r;
    ks_valid_nxt_s = ks_valid_r;
    ks_data_nxt_s  = ks_data_r;
    word_cnt_nxt_s = word_cnt_r;
    if (bus.load) begin
      s_nxt_s        = s_load_s;
      ctr_nxt_s      = '0;
      busy_nxt_s     = 1'b1;
      ks_valid_nxt_s = 1'b0;
      word_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          s_nxt_s = s_r;
        end
        ST_INIT: begin
          s_nxt_s   = s_adv_s;
          ctr_nxt_s = ctr_r + CTR_W'(W);
          if (init_last_s) begin
            busy_nxt_s = 1'b0;
          end else begin
            busy_nxt_s = 1'b1;
          end
        end
        ST_RUN: begin
          if (handshake_s) begin
            word_cnt_nxt_s = word_cnt_r + CNT_W'(1);
          end else begin
            word_cnt_nxt_s = word_cnt_r;
          end
          // The cipher only steps when the held word is gone, so nothing is skipped or repeated.
          if (advance_s) begin
            s_nxt_s        = s_adv_s;
            ks_data_nxt_s  = z_s;
            ks_valid_nxt_s = 1'b1;
          end else begin
            s_nxt_s        = s_r;
            ks_data_nxt_s  = ks_data_r;
            ks_valid_nxt_s = ks_valid_r;
          end
        end
        default: begin
          s_nxt_s = s_r;
        end
      endcase
    end
  end

  // Cipher state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r        <= 288'd0;
      ctr_r      <= '0;
      busy_r     <= 1'b0;
      ks_valid_r <= 1'b0;
      ks_data_r  <= '0;
      word_cnt_r <= '0;
    end else begin
      s_r        <= s_nxt_s;
      ctr_r      <= ctr_nxt_s;
      busy_r     <= busy_nxt_s;
      ks_valid_r <= ks_valid_nxt_s;
      ks_data_r  <= ks_data_nxt_s;
      word_cnt_r <= word_cnt_nxt_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.ks_valid = ks_valid_r;
  assign bus.ks_data  = ks_data_r;
  assign bus.word_cnt = word_cnt_r;
endmodule
